// File: rtl/free_list_mw_pkg.sv
// Shared rename-stage types and sizing for the multi-port free list.
// No logic; latency and backpressure are defined by the users of these types.
package free_list_mw_pkg;

    localparam int PREGS     = 64;
    localparam int PHYS_REGS = PREGS;
    localparam int PREG_W    = $clog2(PREGS);
    localparam int ARCH_REGS = 32;
    localparam int ALLOC_W   = 2;
    localparam int FREE_W    = 2;
    localparam int NUM_CKPT  = 4;
    localparam int CKPT_W    = $clog2(NUM_CKPT);

    typedef logic [PREG_W-1:0] preg_t;
    // Extra MSB is the wrap bit, so full and empty are distinguishable.
    typedef logic [PREG_W:0]   ptr_t;
    typedef logic [CKPT_W-1:0] ckpt_id_t;

    function automatic ptr_t lane_count(input logic [31:0] mask, input int lanes);
        ptr_t n;
        n = '0;
        for (int i = 0; i < lanes; i++) begin
            if (mask[i]) n = n + ptr_t'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/free_list_mw_if.sv
// Rename/commit-facing bundle of the free list: alloc lanes, free lanes, checkpoints.
// Pure wiring; alloc_ready is the only backpressure and it is all-or-nothing.
interface free_list_mw_if;
    import free_list_mw_pkg::*;

    logic [ALLOC_W-1:0]  alloc_req;
    preg_t [ALLOC_W-1:0] alloc_phys;
    logic                alloc_ready;
    logic [FREE_W-1:0]   free_en;
    preg_t [FREE_W-1:0]  free_phys;
    logic                ckpt_save;
    ckpt_id_t            ckpt_save_id;
    logic                ckpt_restore;
    ckpt_id_t            ckpt_restore_id;
    ptr_t                free_count;
    logic                overflow_err;

    modport master (
        output alloc_req, free_en, free_phys,
        output ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id,
        input  alloc_phys, alloc_ready, free_count, overflow_err
    );

    modport slave (
        input  alloc_req, free_en, free_phys,
        input  ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id,
        output alloc_phys, alloc_ready, free_count, overflow_err
    );

endinterface

// File: rtl/free_list_ckpt_file.sv
// Head-pointer snapshot slots: one write port, combinational read port.
// Write lands at the clock edge; read is same-cycle; never stalls.
module free_list_ckpt_file
    import free_list_mw_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     wr_en,
    input  ckpt_id_t wr_id,
    input  ptr_t     wr_ptr,
    input  ckpt_id_t rd_id,
    output ptr_t     rd_ptr
);

    ptr_t slots [NUM_CKPT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CKPT; i++) slots[i] <= '0;
        end else if (wr_en) begin
            slots[wr_id] <= wr_ptr;
        end
    end

    assign rd_ptr = slots[rd_id];

endmodule

// File: rtl/free_list_mw.sv
// Multi-port circular free list of physical registers with head checkpoints.
// Alloc/free visible next cycle; alloc_ready gates all lanes together, overflowing frees are dropped.
module free_list_mw
    import free_list_mw_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    free_list_mw_if.slave  fl
);

    preg_t fifo [PHYS_REGS];
    ptr_t  head, tail;
    ptr_t  free_count_q;
    logic  overflow_err_q;

    ptr_t  count, alloc_n, free_n;
    ptr_t  head_after_alloc, head_nxt, tail_nxt, ckpt_rd;
    ptr_t  alloc_off, free_off;
    logic  alloc_fire, free_ok;
    preg_t [ALLOC_W-1:0] peek;
    preg_t wr_idx [FREE_W];

    assign count   = tail - head;
    assign alloc_n = lane_count(32'(fl.alloc_req), ALLOC_W);
    assign free_n  = lane_count(32'(fl.free_en), FREE_W);

    // Readiness uses the registered occupancy only; same-cycle frees are not bypassed.
    assign fl.alloc_ready    = (alloc_n <= count);
    assign alloc_fire        = fl.alloc_ready && (|fl.alloc_req) && !fl.ckpt_restore;
    assign head_after_alloc  = alloc_fire ? (head + alloc_n) : head;
    assign head_nxt          = fl.ckpt_restore ? ckpt_rd : head_after_alloc;

    // One extra bit so a full list plus a free group cannot wrap the compare.
    assign free_ok  = ({1'b0, count} + {1'b0, free_n}) <= (PREG_W+2)'(PHYS_REGS);
    assign tail_nxt = free_ok ? (tail + free_n) : tail;

    // Requesting lanes are packed in lane order; idle lanes show head+i.
    always_comb begin
        alloc_off = '0;
        peek      = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (fl.alloc_req[i]) begin
                peek[i]   = fifo[preg_t'(head + alloc_off)];
                alloc_off = alloc_off + ptr_t'(1);
            end else begin
                peek[i]   = fifo[preg_t'(head + ptr_t'(i))];
            end
        end
    end

    always_comb begin
        free_off = '0;
        for (int j = 0; j < FREE_W; j++) begin
            wr_idx[j] = preg_t'(tail + free_off);
            if (fl.free_en[j]) free_off = free_off + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                fifo[i] <= (i < PHYS_REGS - ARCH_REGS) ? preg_t'(ARCH_REGS + i) : '0;
            end
            head           <= '0;
            tail           <= ptr_t'(PHYS_REGS - ARCH_REGS);
            free_count_q   <= ptr_t'(PHYS_REGS - ARCH_REGS);
            overflow_err_q <= 1'b0;
        end else begin
            head         <= head_nxt;
            tail         <= tail_nxt;
            free_count_q <= tail_nxt - head_nxt;
            if (!free_ok) overflow_err_q <= 1'b1;
            if (free_ok) begin
                for (int j = 0; j < FREE_W; j++) begin
                    if (fl.free_en[j]) fifo[wr_idx[j]] <= fl.free_phys[j];
                end
            end
        end
    end

    // A restore wins over a save issued in the same cycle.
    free_list_ckpt_file u_ckpt (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (fl.ckpt_save && !fl.ckpt_restore),
        .wr_id  (fl.ckpt_save_id),
        .wr_ptr (head_after_alloc),
        .rd_id  (fl.ckpt_restore_id),
        .rd_ptr (ckpt_rd)
    );

    assign fl.alloc_phys   = peek;
    assign fl.free_count   = free_count_q;
    assign fl.overflow_err = overflow_err_q;

endmodule

// File: tb/tb_free_list_mw.sv
// Bench for free_list_mw: directed scenarios plus random traffic against an array/pointer model.
module tb_free_list_mw;
    import free_list_mw_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    free_list_mw_if bus();

    free_list_mw dut (
        .clk   (clk),
        .reset (reset),
        .fl    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: unbounded-style pointers kept modulo 128, storage modulo 64.
    int m_mem [64];
    int m_ck [4];
    int m_head, m_tail;
    bit m_ovf;

    function automatic int pc(input int v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += (v >> i) & 1;
        return c;
    endfunction

    function automatic int m_count();
        return (m_tail - m_head) & 127;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = (i < 32) ? 32 + i : 0;
        for (int i = 0; i < 4; i++) m_ck[i] = 0;
        m_head = 0;
        m_tail = 32;
        m_ovf  = 1'b0;
    endtask

    task automatic model_clock();
        int n, cnt, ha, nh, fn, k;
        bit fire;
        n    = pc(int'(bus.alloc_req));
        cnt  = m_count();
        fire = (n <= cnt) && (n > 0) && !bus.ckpt_restore;
        ha   = (m_head + (fire ? n : 0)) & 127;
        nh   = bus.ckpt_restore ? m_ck[bus.ckpt_restore_id] : ha;
        if (bus.ckpt_save && !bus.ckpt_restore) m_ck[bus.ckpt_save_id] = ha;
        fn = pc(int'(bus.free_en));
        if (cnt + fn > 64) begin
            m_ovf = 1'b1;
        end else begin
            k = 0;
            for (int j = 0; j < 2; j++) begin
                if (bus.free_en[j]) begin
                    m_mem[(m_tail + k) & 63] = int'(bus.free_phys[j]);
                    k++;
                end
            end
            m_tail = (m_tail + fn) & 127;
        end
        m_head = nh;
    endtask

    task automatic compare_outputs();
        int cnt, n, off;
        cnt = m_count();
        n   = pc(int'(bus.alloc_req));
        check("free_count", int'(bus.free_count), cnt);
        check("overflow_err", int'(bus.overflow_err), int'(m_ovf));
        check("alloc_ready", int'(bus.alloc_ready), (n <= cnt) ? 1 : 0);
        off = 0;
        for (int i = 0; i < 2; i++) begin
            if (bus.alloc_req[i]) begin
                check("alloc_phys", int'(bus.alloc_phys[i]), m_mem[(m_head + off) & 63]);
                off++;
            end else if (bus.alloc_req == '0) begin
                check("alloc_phys_idle", int'(bus.alloc_phys[i]), m_mem[(m_head + i) & 63]);
            end
        end
    endtask

    task automatic set_idle();
        bus.alloc_req       = '0;
        bus.free_en         = '0;
        bus.free_phys       = '0;
        bus.ckpt_save       = 1'b0;
        bus.ckpt_save_id    = '0;
        bus.ckpt_restore    = 1'b0;
        bus.ckpt_restore_id = '0;
    endtask

    task automatic step();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int h0, h1;
        set_idle();

        // Reset state
        do_reset();
        check("t1_count", int'(bus.free_count), 32);
        check("t1_phys0", int'(bus.alloc_phys[0]), 32);
        check("t1_phys1", int'(bus.alloc_phys[1]), 33);
        check("t1_ovf", int'(bus.overflow_err), 0);
        bus.alloc_req = 2'b11;
        #1 check("t1_ready", int'(bus.alloc_ready), 1);
        step();

        // Two-lane then single upper-lane allocation
        bus.alloc_req = 2'b00;
        #1;
        check("t2_phys0", int'(bus.alloc_phys[0]), 34);
        check("t2_phys1", int'(bus.alloc_phys[1]), 35);
        check("t2_count", int'(bus.free_count), 30);
        bus.alloc_req = 2'b10;
        #1 check("t2_lane1", int'(bus.alloc_phys[1]), 34);
        step();
        bus.alloc_req = 2'b00;
        #1 check("t2_count1", int'(bus.free_count), 29);

        // Drain to empty, then refill with a blocked same-cycle alloc
        do_reset();
        bus.alloc_req = 2'b11;
        repeat (16) step();
        bus.alloc_req = 2'b01;
        #1;
        check("t3_ready_empty", int'(bus.alloc_ready), 0);
        check("t3_count_empty", int'(bus.free_count), 0);
        bus.alloc_req    = 2'b11;
        bus.free_en      = 2'b11;
        bus.free_phys[0] = preg_t'(5);
        bus.free_phys[1] = preg_t'(7);
        #1 check("t3_ready_same", int'(bus.alloc_ready), 0);
        step();
        set_idle();
        #1;
        check("t3_count", int'(bus.free_count), 2);
        check("t3_phys0", int'(bus.alloc_phys[0]), 5);
        check("t3_phys1", int'(bus.alloc_phys[1]), 7);
        step();

        // Checkpoint save with alloc, then restore with ignored alloc
        do_reset();
        bus.alloc_req    = 2'b11;
        bus.ckpt_save    = 1'b1;
        bus.ckpt_save_id = 2'd1;
        step();
        bus.ckpt_save = 1'b0;
        step();
        step();
        bus.alloc_req = 2'b00;
        #1 check("t4_count", int'(bus.free_count), 26);
        bus.alloc_req       = 2'b11;
        bus.ckpt_restore    = 1'b1;
        bus.ckpt_restore_id = 2'd1;
        step();
        set_idle();
        #1;
        check("t4_count_rst", int'(bus.free_count), 30);
        check("t4_phys0", int'(bus.alloc_phys[0]), 34);
        check("t4_phys1", int'(bus.alloc_phys[1]), 35);
        step();

        // Fill to full, then an overflowing free
        do_reset();
        for (int k = 0; k < 16; k++) begin
            bus.free_en      = 2'b11;
            bus.free_phys[0] = preg_t'(2 * k);
            bus.free_phys[1] = preg_t'(2 * k + 1);
            step();
        end
        set_idle();
        #1 check("t5_full", int'(bus.free_count), 64);
        bus.free_en      = 2'b01;
        bus.free_phys[0] = preg_t'(40);
        step();
        set_idle();
        #1;
        check("t5_count_drop", int'(bus.free_count), 64);
        check("t5_ovf", int'(bus.overflow_err), 1);
        repeat (3) step();
        check("t5_ovf_sticky", int'(bus.overflow_err), 1);
        do_reset();
        check("t5_ovf_clr", int'(bus.overflow_err), 0);

        // Wrap: alternate allocate and recycle so both pointers pass 64
        for (int k = 0; k < 40; k++) begin
            h0 = m_mem[m_head & 63];
            h1 = m_mem[(m_head + 1) & 63];
            set_idle();
            bus.alloc_req = 2'b11;
            step();
            set_idle();
            bus.free_en      = 2'b11;
            bus.free_phys[0] = preg_t'(h0);
            bus.free_phys[1] = preg_t'(h1);
            step();
            check("t6_count", int'(bus.free_count), 32);
        end

        // Random traffic
        do_reset();
        for (int k = 0; k < 800; k++) begin
            set_idle();
            bus.alloc_req       = 2'($urandom_range(0, 3));
            bus.free_en         = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            bus.free_phys[0]    = preg_t'($urandom);
            bus.free_phys[1]    = preg_t'($urandom);
            bus.ckpt_save       = ($urandom_range(0, 7) == 0);
            bus.ckpt_save_id    = ckpt_id_t'($urandom);
            bus.ckpt_restore    = ($urandom_range(0, 15) == 0);
            bus.ckpt_restore_id = ckpt_id_t'($urandom);
            step();
        end
        set_idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/free_list_mw.md
Name: free_list_mw

Overview:
- Multi-port physical-register free list for the superscalar rename stage.
- Circular FIFO of free pregs.
  - Up to ALLOC_W pregs allocated per cycle at the head.
  - Up to FREE_W pregs returned per cycle at the tail (from commit).
- Head-pointer checkpoints for branch-mispredict recovery.
- Replaces the single-port free list; sits between rename and ROB commit.

Parameters:
- PHYS_REGS, core_pkg::PREGS (64): physical registers = FIFO depth; must be a power of two.
- ARCH_REGS, 32: pregs 0..ARCH_REGS-1 are mapped at reset and are not on the list.
- ALLOC_W, 2: allocation lanes.
- FREE_W, 2: free lanes.
- NUM_CKPT, 4: checkpoint slots.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- alloc_req  in  ALLOC_W  per-lane allocate request.
- alloc_phys  out  ALLOC_W x PREG_W  preg offered to each lane (combinational peek).
- alloc_ready  out  1  all requested lanes can be satisfied this cycle.
- free_en  in  FREE_W  per-lane free valid.
- free_phys  in  FREE_W x PREG_W  preg being freed.
- ckpt_save  in  1  snapshot the head pointer.
- ckpt_save_id  in  CKPT_W  slot to write.
- ckpt_restore  in  1  restore the head pointer.
- ckpt_restore_id  in  CKPT_W  slot to read.
- free_count  out  PREG_W+1  registered count of free entries.
- overflow_err  out  1  sticky error flag.

Behaviour:
- State
  - fifo[PHYS_REGS] of preg_t.
  - head and tail pointers, each PREG_W+1 bits; the MSB is the wrap bit.
  - count = tail - head (modulo 2^(PREG_W+1)).
- Reset (synchronous)
  - fifo[i] = ARCH_REGS+i for i < PHYS_REGS-ARCH_REGS; other entries 0.
  - head = 0; tail = PHYS_REGS-ARCH_REGS; checkpoint slots = 0.
  - overflow_err = 0; free_count = 32.
  - Outputs after reset: alloc_phys[i] = ARCH_REGS+i.
- Alloc lane mapping
  - Lane i is offered fifo[head + popcount(alloc_req[i-1:0])], so requesting lanes are compacted in lane order.
  - Lanes that do not request still show a value; it is don't-care.
- alloc_ready = (popcount(alloc_req) <= count). Uses the registered count only; same-cycle frees are not bypassed.
- Alloc commit
  - At the clock edge, if alloc_ready and any request and no ckpt_restore: head += popcount(alloc_req).
  - All-or-nothing: when alloc_ready=0, no allocation occurs.
- Free
  - Each asserted free lane writes fifo[tail + popcount(free_en[j-1:0])] = free_phys[j].
  - tail += popcount(free_en).
  - Frees are applied regardless of alloc or restore.
- Overflow
  - Condition: count + popcount(free_en) > PHYS_REGS.
  - Response: the whole free group is dropped, tail is unchanged, and overflow_err is set and held until reset.
- Checkpoint save
  - ckpt[ckpt_save_id] = head value after this cycle's allocation, so it includes allocs granted in the same cycle.
- Checkpoint restore
  - Next head = ckpt[ckpt_restore_id].
  - Restore has priority: a same-cycle alloc is not performed and a same-cycle save is ignored.
  - count is recomputed from the pointers; no stored count.
- Full/empty
  - count=0 means any request gives alloc_ready=0.
  - count=PHYS_REGS is legal; head and tail indices are equal with differing wrap bits.
- Wrap
  - Pointer index = low PREG_W bits.
  - Wrap is natural modulo arithmetic; no special-case logic.
- Latency
  - Alloc is visible in alloc_phys and free_count the next cycle.
  - A freed preg is allocatable in the cycle after the free at the earliest.

Decomposition:
- core_pkg additions:
  - PREG_W = $clog2(PREGS).
  - ARCH_REGS.
  - typedef preg_t (logic [PREG_W-1:0]).
  - CKPT_W and typedef ckpt_id_t.
- One sub-module, free_list_ckpt_file: NUM_CKPT x (PREG_W+1) register file.
  - Write port: save.
  - Combinational read port: restore.
  - Synchronous reset.

Test Plan:
1. Reset, then idle -> alloc_phys={32,33}, free_count=32, alloc_ready=1 for req=11, overflow_err=0.
2. req=11 for 1 cycle -> next cycle alloc_phys={34,35}, free_count=30.
   Then req=10 (lane 1 only) -> lane 1 receives 34; next cycle free_count=29.
3. From reset: 16 cycles of req=11 -> free_count=0 and alloc_ready=0 for req=01.
   Then free_en=11, free_phys={5,7} -> next cycle free_count=2, alloc_phys={5,7}.
   Same-cycle req=11 during the free cycle -> not granted.
4. From reset: req=11 with ckpt_save id=1 -> saved head=2.
   Then two more cycles of req=11 (free_count=26).
   Then ckpt_restore id=1 with req=11 -> alloc ignored; next cycle free_count=30, alloc_phys={34,35}.
5. From reset: 16 cycles free_en=11 of pregs 0..31 -> free_count=64.
   Then free_en=01 phys=40 -> dropped, free_count=64, overflow_err=1 until reset.
6. Wrap: alternate 40 cycles of req=11 with free_en=11 recycling the returned pregs, so pointers pass 64 -> free_count stays 32, and alloc_phys matches the FIFO order of a scoreboard model every cycle.
